// File: rtl/loader_pkg.sv
// Shared types and widths for the instruction-memory boot loader.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_COUNT,
    ST_LOAD,
    ST_CHECKSUM,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam int BYTE_POS_W = 2;
  localparam int CHECKSUM_W = 8;

endpackage

// File: rtl/byte_to_word_assembler.sv
// Collects four accepted bytes into a little-endian word and pulses on the fourth.
module byte_to_word_assembler
  import loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_complete
);

  logic [BYTE_POS_W-1:0] r_pos;
  logic [23:0]           r_shift;

  // Only the three earlier bytes are stored; the fourth is taken straight from the input.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pos   <= '0;
      r_shift <= '0;
    end else if (i_accept) begin
      r_pos   <= r_pos + 1'b1;
      r_shift <= {i_byte, r_shift[23:8]};
    end
  end

  assign o_word     = {i_byte, r_shift};
  assign o_complete = i_accept && (r_pos == 2'd3);

endmodule

// File: rtl/instruction_memory_loader.sv
// Boot-time loader: framed byte stream -> instruction-memory writes, holds the core until verified.
module instruction_memory_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS   = 32'h0000_0000,
  parameter int          MAX_WORDS      = 256,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        byteValid,
  input  logic [7:0]  byteData,
  output logic        byteReady,
  output logic        imemWriteEnable,
  output logic [31:0] imemWriteAddress,
  output logic [31:0] imemWriteData,
  output logic        cpuHold,
  output logic        loadDone,
  output logic        loadError
);

  localparam logic [31:0] MAX_WORDS_L = 32'(MAX_WORDS);
  localparam logic [31:0] IDLE_LAST   = 32'(TIMEOUT_CYCLES - 1);

  state_t                r_state;
  state_t                w_next;
  logic                  r_armed;
  logic                  r_started;
  logic [31:0]           r_idle;
  logic [31:0]           r_count;
  logic [31:0]           r_word_idx;
  logic [CHECKSUM_W-1:0] r_csum;
  logic                  r_we;
  logic [31:0]           r_waddr;
  logic [31:0]           r_wdata;

  logic                  w_active;
  logic                  w_byte_ready;
  logic                  w_done;
  logic                  w_error;
  logic                  w_accept;
  logic [31:0]           w_word;
  logic                  w_word_complete;
  logic                  w_timeout;
  logic                  w_last_word;

  assign w_active    = (r_state == ST_COUNT) || (r_state == ST_LOAD) ||
                       (r_state == ST_CHECKSUM);
  assign w_accept    = byteValid && w_byte_ready;
  assign w_timeout   = r_started && w_active && !w_accept && (r_idle == IDLE_LAST);
  assign w_last_word = (r_word_idx == (r_count - 32'd1));

  byte_to_word_assembler u_assembler (
    .clock      (clock),
    .reset      (reset),
    .i_accept   (w_accept && (r_state != ST_CHECKSUM)),
    .i_byte     (byteData),
    .o_word     (w_word),
    .o_complete (w_word_complete)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_COUNT;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_COUNT: begin
        if (w_word_complete)
          w_next = ((w_word == 32'd0) || (w_word > MAX_WORDS_L)) ? ST_ERROR : ST_LOAD;
      end
      ST_LOAD: begin
        if (w_word_complete && w_last_word) w_next = ST_CHECKSUM;
      end
      ST_CHECKSUM: begin
        if (w_accept) w_next = (byteData == r_csum) ? ST_DONE : ST_ERROR;
      end
      default: w_next = r_state;
    endcase
    if (w_timeout) w_next = ST_ERROR;
  end

  // r_armed keeps byteReady low for the first clock out of reset.
  always_comb begin
    w_byte_ready = r_armed && w_active;
    w_done       = (r_state == ST_DONE);
    w_error      = (r_state == ST_ERROR);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_armed    <= 1'b0;
      r_started  <= 1'b0;
      r_idle     <= '0;
      r_count    <= '0;
      r_word_idx <= '0;
      r_csum     <= '0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      r_armed <= 1'b1;
      r_we    <= 1'b0;
      if (w_accept) begin
        r_started <= 1'b1;
        r_idle    <= '0;
      end else if (r_started && w_active) begin
        r_idle <= r_idle + 32'd1;
      end
      if ((r_state == ST_COUNT) && w_word_complete) begin
        r_count    <= w_word;
        r_word_idx <= '0;
      end
      if ((r_state == ST_LOAD) && w_accept) r_csum <= r_csum ^ byteData;
      if ((r_state == ST_LOAD) && w_word_complete) begin
        r_we       <= 1'b1;
        r_waddr    <= BASE_ADDRESS + {r_word_idx[29:0], 2'b00};
        r_wdata    <= w_word;
        r_word_idx <= r_word_idx + 32'd1;
      end
    end
  end

  assign byteReady        = w_byte_ready;
  assign imemWriteEnable  = r_we;
  assign imemWriteAddress = r_waddr;
  assign imemWriteData    = r_wdata;
  assign loadDone         = w_done;
  assign loadError        = w_error;
  assign cpuHold          = !w_done;

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Scoreboard bench for instruction_memory_loader: directed frames, expected writes queued per frame.
module tb_instruction_memory_loader;

  localparam int TO = 64;

  logic        clock = 1'b0;
  logic        reset;
  logic        byteValid;
  logic [7:0]  byteData;
  logic        byteReady;
  logic        imemWriteEnable;
  logic [31:0] imemWriteAddress;
  logic [31:0] imemWriteData;
  logic        cpuHold;
  logic        loadDone;
  logic        loadError;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [7:0]  stim[$];

  always #5 clock = ~clock;

  instruction_memory_loader #(
    .BASE_ADDRESS  (32'h0000_0000),
    .MAX_WORDS     (256),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .byteValid       (byteValid),
    .byteData        (byteData),
    .byteReady       (byteReady),
    .imemWriteEnable (imemWriteEnable),
    .imemWriteAddress(imemWriteAddress),
    .imemWriteData   (imemWriteData),
    .cpuHold         (cpuHold),
    .loadDone        (loadDone),
    .loadError       (loadError)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest queued write.
  initial begin
    forever begin
      @(negedge clock);
      if (imemWriteEnable === 1'b1) begin
        if (exp_addr.size() == 0) begin
          chk("unexpected_write_addr", imemWriteAddress, 32'hFFFF_FFFF);
        end else begin
          logic [31:0] ea;
          logic [31:0] ed;
          ea = exp_addr.pop_front();
          ed = exp_data.pop_front();
          chk("write_addr", imemWriteAddress, ea);
          chk("write_data", imemWriteData, ed);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    byteValid = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byteValid = 1'b1;
    byteData  = b;
    while (!byteReady && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (!byteReady) begin
      chk("byte_ready_wait", 32'(byteReady), 32'd1);
      byteValid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    byteValid = 1'b0;
  endtask

  task automatic send_stim(input int gapmax);
    foreach (stim[i]) begin
      send_byte(stim[i]);
      if (gapmax > 0) idle(int'($urandom_range(0, gapmax)));
    end
  endtask

  task automatic do_reset();
    byteValid = 1'b0;
    byteData  = 8'h00;
    reset     = 1'b1;
    idle(2);
    reset     = 1'b0;
  endtask

  task automatic set_frame(input logic [7:0] cs);
    stim = {8'h02, 8'h00, 8'h00, 8'h00,
            8'h93, 8'h00, 8'h50, 8'h00,
            8'h13, 8'h01, 8'h10, 8'h00, cs};
  endtask

  task automatic push_both();
    exp_addr.push_back(32'h0000_0000); exp_data.push_back(32'h0050_0093);
    exp_addr.push_back(32'h0000_0004); exp_data.push_back(32'h0010_0113);
  endtask

  task automatic end_check(input string nm, input logic done, input logic err);
    idle(3);
    chk({nm, "_pending_writes"}, 32'(exp_addr.size()), 32'd0);
    chk({nm, "_loadDone"},  32'(loadDone),  32'(done));
    chk({nm, "_loadError"}, 32'(loadError), 32'(err));
    chk({nm, "_cpuHold"},   32'(cpuHold),   32'(!done));
    chk({nm, "_byteReady"}, 32'(byteReady), 32'd0);
    exp_addr.delete();
    exp_data.delete();
  endtask

  initial begin
    reset     = 1'b1;
    byteValid = 1'b0;
    byteData  = 8'h00;
    idle(2);
    chk("rst_byteReady", 32'(byteReady),       32'd0);
    chk("rst_we",        32'(imemWriteEnable), 32'd0);
    chk("rst_addr",      imemWriteAddress,     32'd0);
    chk("rst_data",      imemWriteData,        32'd0);
    chk("rst_cpuHold",   32'(cpuHold),         32'd1);
    chk("rst_loadDone",  32'(loadDone),        32'd0);
    chk("rst_loadError", 32'(loadError),       32'd0);
    reset = 1'b0;

    // Valid N=2 frame, back-to-back
    push_both();
    set_frame(8'hC1);
    send_stim(0);
    end_check("good", 1'b1, 1'b0);

    // Bad checksum
    do_reset();
    push_both();
    set_frame(8'hC0);
    send_stim(0);
    end_check("badcs", 1'b0, 1'b1);

    // Zero word count
    do_reset();
    stim = {8'h00, 8'h00, 8'h00, 8'h00};
    send_stim(0);
    chk("zero_err_now", 32'(loadError), 32'd1);
    end_check("zero", 1'b0, 1'b1);

    // MAX_WORDS+1 = 257
    do_reset();
    stim = {8'h01, 8'h01, 8'h00, 8'h00};
    send_stim(0);
    chk("over_err_now", 32'(loadError), 32'd1);
    end_check("over", 1'b0, 1'b1);

    // Random gaps well below the timeout
    do_reset();
    push_both();
    set_frame(8'hC1);
    send_stim(TO / 4);
    end_check("gaps", 1'b1, 1'b0);

    // Stall after the 6th byte
    do_reset();
    stim = {8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
    send_stim(0);
    idle(TO - 1);
    chk("stall_before_limit", 32'(loadError), 32'd0);
    idle(1);
    chk("stall_at_limit", 32'(loadError), 32'd1);
    end_check("stall", 1'b0, 1'b1);

    // Reset in the middle of word 1, then a full frame
    do_reset();
    exp_addr.push_back(32'h0000_0000); exp_data.push_back(32'h0050_0093);
    stim = {8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01};
    send_stim(0);
    chk("mid_ready_before", 32'(byteReady), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_byteReady", 32'(byteReady),       32'd0);
    chk("mid_we",        32'(imemWriteEnable), 32'd0);
    chk("mid_data",      imemWriteData,        32'd0);
    chk("mid_addr",      imemWriteAddress,     32'd0);
    chk("mid_cpuHold",   32'(cpuHold),         32'd1);
    chk("mid_pending",   32'(exp_addr.size()), 32'd0);
    idle(2);
    reset = 1'b0;
    push_both();
    set_frame(8'hC1);
    send_stim(0);
    end_check("reload", 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_memory_loader.md
Name: instruction_memory_loader

Overview:
Boot-time writer for the instruction memory that the fetch stage reads. It accepts a byte stream over a valid/ready handshake, checks the framing, and assembles little-endian 32-bit words. It drives the instruction-memory write port and holds the processor core in reset until the load is complete and verified. It sits between the external load interface and instruction memory, and drives the core's hold.

Parameters:
BASE_ADDRESS, 32'h0000_0000, byte address of the first written word
MAX_WORDS, 256, largest accepted word count; must fit instruction memory
TIMEOUT_CYCLES, 1024, idle cycles allowed between bytes once a frame has started

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
byteValid  input  1  byteData is valid this cycle
byteData  input  8  stream byte
byteReady  output  1  loader accepts a byte; transfer occurs when byteValid && byteReady
imemWriteEnable  output  1  one-cycle instruction-memory write strobe
imemWriteAddress  output  32  byte address of the write, word aligned
imemWriteData  output  32  instruction word
cpuHold  output  1  holds the core in reset while high
loadDone  output  1  frame loaded and checksum matched (sticky)
loadError  output  1  frame rejected (sticky)

Behaviour:
- Reset is asynchronous and active-high. Every register clears. Reset values: byteReady=0, imemWriteEnable=0, imemWriteAddress=0, imemWriteData=0, cpuHold=1, loadDone=0, loadError=0. The state machine enters COUNT on the first clock after reset deasserts.
- Frame format:
  - 4 bytes of word count N, little-endian
  - 4*N payload bytes; each word is little-endian (first byte = bits [7:0])
  - 1 checksum byte, equal to the XOR of all payload bytes (count bytes excluded)
- States: COUNT, LOAD, CHECKSUM, DONE, ERROR.
- COUNT:
  - byteReady=1; collect 4 bytes into the count register.
  - On the 4th accepted byte: if N==0 or N>MAX_WORDS, go to ERROR; otherwise go to LOAD with wordIndex=0.
- LOAD:
  - byteReady=1; shift bytes into the word assembler and XOR each byte into the checksum accumulator.
  - The cycle after the 4th byte of a word is accepted:
    - imemWriteEnable=1 for exactly one cycle
    - imemWriteAddress = BASE_ADDRESS + 4*wordIndex (32-bit wraparound)
    - imemWriteData = the assembled word
    - wordIndex increments
  - After word N-1 is accepted, go to CHECKSUM.
  - Accepting the first byte of the next word in the same cycle as the strobe is legal.
- CHECKSUM:
  - byteReady=1; accept one byte.
  - Equal to the accumulator: go to DONE. Otherwise: go to ERROR.
- DONE: byteReady=0, cpuHold=0, loadDone=1. Further stream activity is ignored. Remains until reset.
- ERROR: byteReady=0, cpuHold=1, loadError=1. No further writes. Remains until reset. Words already written are not rolled back.
- The byte transfer rate is unrestricted; back-to-back bytes every cycle must be sustained with no bubbles.
- Timeout:
  - The idle counter clears on every accepted byte. It counts only once the first count byte has been accepted and the state is not DONE or ERROR.
  - When it reaches TIMEOUT_CYCLES, go to ERROR.
  - No timeout applies before the first byte of a frame.
- loadDone and loadError are never high together. cpuHold = !loadDone at all times.
- Reset mid-frame aborts the load immediately: outputs return to reset values and a fresh frame is expected.

Decomposition:
- Shared package loader_pkg holds:
  - the state enum (COUNT, LOAD, CHECKSUM, DONE, ERROR)
  - the byte-position width constant
  - the checksum width constant
- One natural sub-module: byte_to_word_assembler. It contains the 2-bit byte counter, the little-endian shift register and a word-complete pulse, and is reused for both the count field and the payload words.
- The FSM, checksum accumulator, timeout counter and address generator live in the top.

Test Plan:
- Valid frame with N=2: bytes 02 00 00 00, 93 00 50 00, 13 01 10 00, then checksum C1, sent back-to-back.
  Required: write 0x00500093 at address 0x0, write 0x00100113 at address 0x4, one strobe each; then loadDone=1, cpuHold=0, byteReady=0.
- Same frame with checksum 0xC0.
  Required: both writes occur; then loadError=1, cpuHold stays 1, loadDone=0.
- Count 00 00 00 00, and separately count MAX_WORDS+1.
  Required: ERROR immediately after the 4th count byte; no imemWriteEnable pulse.
- Valid frame with random byteValid gaps shorter than TIMEOUT_CYCLES.
  Required: identical writes and loadDone=1.
- Stall of TIMEOUT_CYCLES after the 6th byte.
  Required: loadError=1; no writes.
- Reset asserted in the middle of word 1, followed by a full valid frame.
  Required: outputs return to reset values asynchronously; the second frame loads correctly from BASE_ADDRESS.
